// File: rtl/sys_array_pkg.sv
// Shared definitions for the systolic MNIST array: load-FSM states, default
// word/bank sizes shared with the bias ROM, and the packed-slice offset helper.
package sys_array_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_SIZE       = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StChk,
        StDone
    } load_state_e;

    // Bit offset of word t inside a packed bank of w-bit words.
    function automatic int unsigned pack_off(input int unsigned t,
                                             input int unsigned w = DEF_DATA_WIDTH);
        return w * t;
    endfunction

endpackage

// File: rtl/bias_bank_loader.sv
// Writer side of the packed bias/weight bank. After a start pulse it takes SIZE
// words over a valid/ready handshake and stores word t at bits
// [DATA_WIDTH*t +: DATA_WIDTH] of data_bank_o.
// Optional build macro BIAS_LOAD_CHECKSUM_EN: one extra checksum word is taken
// after the bank words and compared against the modulo-2^DATA_WIDTH running sum.
module bias_bank_loader
    import sys_array_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned SIZE       = DEF_SIZE,
    localparam int unsigned IDX_W     = $clog2(SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [DATA_WIDTH-1:0]      in_data_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [DATA_WIDTH*SIZE-1:0] data_bank_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o
);

    load_state_e                 state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [DATA_WIDTH*SIZE-1:0]  bank_q, bank_d;
    logic                        xfer;
    logic                        last;

    // Handshake flags decode from the state register only, so in_ready_o never
    // depends combinationally on in_valid_i.
    always_comb begin
        in_ready_o = (state_q == StLoad) || (state_q == StChk);
        busy_o     = in_ready_o;
        done_o     = (state_q == StDone);
        xfer       = in_valid_i && in_ready_o;
        last       = (idx_q == IDX_W'(SIZE - 1));
    end

    // Next state, write index and bank update; unwritten words keep old values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bank_d  = bank_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StLoad;
                    idx_d   = '0;
                end
            end
            StLoad: begin
                if (xfer) begin
                    bank_d[pack_off(32'(idx_q), DATA_WIDTH) +: DATA_WIDTH] = in_data_i;
                    if (last) begin
                        idx_d = '0;
`ifdef BIAS_LOAD_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StDone;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef BIAS_LOAD_CHECKSUM_EN
            StChk: begin
                if (xfer) begin
                    state_d = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // State, index and bank registers; reset discards any partial load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bank_q  <= bank_d;
        end
    end

    assign data_bank_o = bank_q;

`ifdef BIAS_LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;
    logic                  err_q;

    // Running sum over bank words, then compare against the trailing checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (start_i && ((state_q == StIdle) || (state_q == StDone))) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (xfer && (state_q == StLoad)) begin
            sum_q <= sum_q + in_data_i;
        end else if (xfer && (state_q == StChk)) begin
            err_q <= (in_data_i != sum_q);
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bias_bank_loader.sv
// Directed bench for bias_bank_loader (SIZE=16, DATA_WIDTH=8). Inputs change
// 1 ns after the rising edge; outputs are sampled there too.
// Honours BIAS_LOAD_CHECKSUM_EN by sending the trailing checksum word.
module tb_bias_bank_loader;

    localparam int unsigned DW = 8;
    localparam int unsigned SZ = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_i = 1'b0;
    logic [DW-1:0]   in_data_i = '0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [DW*SZ-1:0] data_bank_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bias_bank_loader #(
        .DATA_WIDTH(DW),
        .SIZE      (SZ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .data_bank_o(data_bank_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    task automatic check(input string tag, input logic [DW*SZ-1:0] got,
                         input logic [DW*SZ-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // gap idle cycles with in_valid low, then one cycle presenting d.
    task automatic push(input logic [DW-1:0] d, input int gap);
        in_valid_i = 1'b0;
        repeat (gap) step();
        in_valid_i = 1'b1;
        in_data_i  = d;
        step();
        in_valid_i = 1'b0;
    endtask

    // Trailing checksum word, only present in the checksum build.
    task automatic send_checksum(input logic [DW-1:0] ck);
`ifdef BIAS_LOAD_CHECKSUM_EN
        push(ck, 0);
`else
        ck = ck;
`endif
    endtask

    logic [DW*SZ-1:0] exp_bank;
    int               rdy_cnt;

    initial begin
        // Reset, then idle with in_valid asserted; nothing must be consumed.
        step();
        step();
        rst = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 8'h77;
        repeat (10) step();
        in_valid_i = 1'b0;
        check("idle_bank", data_bank_o, '0);
        check("idle_busy", {127'd0, busy_o}, '0);
        check("idle_done", {127'd0, done_o}, '0);
        check("idle_ready", {127'd0, in_ready_o}, '0);
        check("idle_err", {127'd0, err_o}, '0);

        // Full load 0x01..0x10 with in_valid held high.
        pulse_start();
        check("load_busy", {127'd0, busy_o}, 128'd1);
        check("load_done_low", {127'd0, done_o}, '0);
        rdy_cnt = 0;
        for (int i = 0; i < int'(SZ); i++) begin
            if (in_ready_o) rdy_cnt++;
            in_valid_i = 1'b1;
            in_data_i  = 8'(i + 1);
            // start during LOAD must be ignored (index keeps counting)
            start_i = (i == 5);
            step();
            if (i == 0) check("word0_next_cycle", {120'd0, data_bank_o[7:0]}, 128'h01);
        end
        in_valid_i = 1'b0;
        start_i = 1'b0;
        send_checksum(8'h88);
        check("ready_cycles", 128'(rdy_cnt), 128'd16);
        check("seq_done", {127'd0, done_o}, 128'd1);
        check("seq_busy_low", {127'd0, busy_o}, '0);
        check("seq_ready_low", {127'd0, in_ready_o}, '0);
        check("seq_word0", {120'd0, data_bank_o[7:0]}, 128'h01);
        check("seq_word15", {120'd0, data_bank_o[127:120]}, 128'h10);
        for (int i = 0; i < int'(SZ); i++) exp_bank[i*8 +: 8] = 8'(i + 1);
        check("seq_bank", data_bank_o, exp_bank);
        check("seq_err", {127'd0, err_o}, '0);
        repeat (3) step();
        check("done_hold", {127'd0, done_o}, 128'd1);
        check("bank_hold", data_bank_o, exp_bank);

        // Same load with in_valid toggling 1/0.
        pulse_start();
        check("restart_done_low", {127'd0, done_o}, '0);
        for (int i = 0; i < int'(SZ); i++) begin
            if (i == int'(SZ) - 1) begin
                in_valid_i = 1'b0;
                step();
                check("tog_done_before_last", {127'd0, done_o}, '0);
                push(8'(i + 1), 0);
            end else begin
                push(8'(i + 1), (i == 0) ? 0 : 1);
            end
        end
        send_checksum(8'h88);
        check("tog_done", {127'd0, done_o}, 128'd1);
        check("tog_bank", data_bank_o, exp_bank);

        // 0xFF x16, then a partial reload of four 0x00 words.
        pulse_start();
        for (int i = 0; i < int'(SZ); i++) push(8'hFF, 0);
        send_checksum(8'hF0);
        check("ff_bank", data_bank_o, {16{8'hFF}});
        pulse_start();
        for (int i = 0; i < 4; i++) push(8'h00, 0);
        check("partial_bank", data_bank_o, {{12{8'hFF}}, {4{8'h00}}});
        check("partial_busy", {127'd0, busy_o}, 128'd1);
        check("partial_done", {127'd0, done_o}, '0);

        // Reset after 8 words: outputs clear without waiting for a clock edge.
        for (int i = 0; i < 4; i++) push(8'h00, 0);
        rst = 1'b1;
        #1;
        check("rst_bank", data_bank_o, '0);
        check("rst_busy", {127'd0, busy_o}, '0);
        check("rst_done", {127'd0, done_o}, '0);
        check("rst_ready", {127'd0, in_ready_o}, '0);
        check("rst_err", {127'd0, err_o}, '0);
        step();
        rst = 1'b0;
        step();
        pulse_start();
        for (int i = 0; i < int'(SZ); i++) push(8'hA5, 0);
        send_checksum(8'h50);
        check("a5_bank", data_bank_o, {16{8'hA5}});
        check("a5_done", {127'd0, done_o}, 128'd1);
        check("a5_err", {127'd0, err_o}, '0);

`ifdef BIAS_LOAD_CHECKSUM_EN
        // Checksum: good then bad.
        pulse_start();
        for (int i = 0; i < int'(SZ); i++) push(8'(i + 1), 0);
        check("chk_wait_done_low", {127'd0, done_o}, '0);
        check("chk_wait_ready", {127'd0, in_ready_o}, 128'd1);
        push(8'h88, 0);
        check("chk_good_done", {127'd0, done_o}, 128'd1);
        check("chk_good_err", {127'd0, err_o}, '0);
        check("chk_good_bank", data_bank_o, exp_bank);
        pulse_start();
        for (int i = 0; i < int'(SZ); i++) push(8'(i + 1), 0);
        push(8'h89, 0);
        check("chk_bad_done", {127'd0, done_o}, 128'd1);
        check("chk_bad_err", {127'd0, err_o}, 128'd1);
        step();
        check("chk_err_hold", {127'd0, err_o}, 128'd1);
        pulse_start();
        check("chk_err_clear", {127'd0, err_o}, '0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
